// File: rtl/tile_sequencer_pkg.sv
// Shared parameters for the small systolic array: array geometry, scratchpad
// sizing and the tile sequencer's state encoding.
package tile_sequencer_pkg;

  localparam int SMALL_SYS_ROWS   = 8;
  localparam int SMALL_SYS_COLS   = 8;
  localparam int SCRATCHPAD_DEPTH = 128;

  localparam int ADDR_W   = $clog2(SCRATCHPAD_DEPTH);
  localparam int PIPE_LAT = SMALL_SYS_ROWS + SMALL_SYS_COLS;

  // Largest tile that fits in one scratchpad; longer requests are cut to this.
  localparam logic [ADDR_W:0]   MAX_ROWS   = (ADDR_W+1)'(SCRATCHPAD_DEPTH);
  // Count value of the final weight row fetched during LOAD_W.
  localparam logic [ADDR_W-1:0] LAST_W_ROW = ADDR_W'(SMALL_SYS_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } seq_state_t;

  // Limit a requested row count to what a scratchpad can hold.
  function automatic logic [ADDR_W:0] clampRows(input logic [ADDR_W:0] rows);
    return (rows > MAX_ROWS) ? MAX_ROWS : rows;
  endfunction

endpackage

// File: rtl/tile_sequencer_delay_line.sv
// Fixed-latency shift register carrying a write-valid flag and the
// activation row index from the read side to the accumulator write side.
module delay_line #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_idx [DEPTH];

  // Shift one stage per cycle; a flush empties every stage so that rows
  // already in flight never reach the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < DEPTH; s++) r_idx[s] <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      for (int s = 0; s < DEPTH; s++) r_idx[s] <= '0;
    end else begin
      r_valid  <= {r_valid[DEPTH-2:0], i_valid};
      r_idx[0] <= i_idx;
      for (int s = 1; s < DEPTH; s++) r_idx[s] <= r_idx[s-1];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/tile_sequencer.sv
// Sequences one matrix tile through the systolic array: preload the weight
// rows, stream activation rows, then wait for the results to drain out into
// the output accumulator scratchpad.
module tile_sequencer
  import tile_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_w_base,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_o_base,
  input  logic [ADDR_W:0]   cmd_rows,
  input  logic              cmd_acc,
  input  logic              abort,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              w_load,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              a_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_acc,
  output logic              busy,
  output logic              done
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [ADDR_W-1:0] r_w_base;
  logic [ADDR_W-1:0] r_a_base;
  logic [ADDR_W-1:0] r_o_base;
  logic [ADDR_W:0]   r_rows;
  logic              r_acc;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_w_load;
  logic              r_a_valid;
  logic              r_done;

  logic              w_accept;
  logic              w_abort;
  logic [ADDR_W:0]   w_cmd_rows;
  logic [ADDR_W:0]   w_last_row;
  logic              w_stream_last;
  logic              w_w_rd_en;
  logic              w_a_rd_en;
  logic              w_dl_valid;
  logic [ADDR_W-1:0] w_dl_idx;
  logic              w_last_wr;

  assign w_accept      = cmd_valid && (r_state == IDLE);
  assign w_abort       = abort && (r_state != IDLE);
  assign w_cmd_rows    = clampRows(cmd_rows);
  assign w_last_row    = r_rows - {{ADDR_W{1'b0}}, 1'b1};
  assign w_stream_last = ({1'b0, r_cnt} == w_last_row);
  assign w_last_wr     = w_dl_valid && ({1'b0, w_dl_idx} == w_last_row);

  // Next-state and read-enable decode; an empty tile never leaves IDLE and
  // an abort overrides every other transition.
  always_comb begin
    w_next    = r_state;
    w_w_rd_en = 1'b0;
    w_a_rd_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (w_cmd_rows != '0)) w_next = LOAD_W;
      end
      LOAD_W: begin
        w_w_rd_en = 1'b1;
        if (r_cnt == LAST_W_ROW) w_next = STREAM;
      end
      STREAM: begin
        w_a_rd_en = 1'b1;
        if (w_stream_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_last_wr) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // State register plus a per-phase row counter that restarts whenever the
  // phase changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the command fields at the handshake so the tile is immune to
  // later changes on the command bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_base <= '0;
      r_a_base <= '0;
      r_o_base <= '0;
      r_rows   <= '0;
      r_acc    <= 1'b0;
    end else if (w_accept) begin
      r_w_base <= cmd_w_base;
      r_a_base <= cmd_a_base;
      r_o_base <= cmd_o_base;
      r_rows   <= w_cmd_rows;
      r_acc    <= cmd_acc;
    end
  end

  // Read data arrives one cycle after the read, so the array-side strobes
  // follow the read enables by one cycle; done fires once the last result
  // has been written, or right away for an empty tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_load  <= 1'b0;
      r_a_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_w_load  <= w_w_rd_en && !w_abort;
      r_a_valid <= w_a_rd_en && !w_abort;
      r_done    <= (w_accept && (w_cmd_rows == '0)) ||
                   ((r_state == DRAIN) && w_last_wr && !w_abort);
    end
  end

  delay_line #(
    .DEPTH (PIPE_LAT),
    .IDX_W (ADDR_W)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_abort),
    .i_valid (w_a_rd_en && !w_abort),
    .i_idx   (r_cnt),
    .o_valid (w_dl_valid),
    .o_idx   (w_dl_idx)
  );

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_rd_en   = w_w_rd_en;
  assign w_rd_addr = w_w_rd_en ? (r_w_base + r_cnt) : '0;
  assign w_load    = r_w_load;
  assign a_rd_en   = w_a_rd_en;
  assign a_rd_addr = w_a_rd_en ? (r_a_base + r_cnt) : '0;
  assign a_valid   = r_a_valid;
  assign o_wr_en   = w_dl_valid;
  assign o_wr_addr = w_dl_valid ? (r_o_base + w_dl_idx) : '0;
  assign o_acc     = w_dl_valid && r_acc;
  assign done      = r_done;

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer: directed tile scenarios plus a
// randomized command/abort stream, compared every cycle against a
// cycle-indexed schedule of expected outputs.
module tb_tile_sequencer;

  localparam int MAXC  = 8192;
  localparam int DEPTH = 128;
  localparam int NROWS = 8;
  localparam int LAT   = 16;

  typedef struct {
    bit wEn;  int wAddr; bit wLoad;
    bit aEn;  int aAddr; bit aValid;
    bit oEn;  int oAddr; bit oAcc;
    bit done; bit busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_w_base;
  logic [6:0] cmd_a_base;
  logic [6:0] cmd_o_base;
  logic [7:0] cmd_rows;
  logic       cmd_acc;
  logic       abort;
  logic       w_rd_en;
  logic [6:0] w_rd_addr;
  logic       w_load;
  logic       a_rd_en;
  logic [6:0] a_rd_addr;
  logic       a_valid;
  logic       o_wr_en;
  logic [6:0] o_wr_addr;
  logic       o_acc;
  logic       busy;
  logic       done;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sched [MAXC];
  int   oWrCyc[$];
  int   oWrAddr[$];
  int   aRdCyc[$];
  int   aRdAddr[$];
  int   wRdCyc[$];
  int   doneCyc[$];

  tile_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_w_base (cmd_w_base),
    .cmd_a_base (cmd_a_base),
    .cmd_o_base (cmd_o_base),
    .cmd_rows   (cmd_rows),
    .cmd_acc    (cmd_acc),
    .abort      (abort),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .w_load     (w_load),
    .a_rd_en    (a_rd_en),
    .a_rd_addr  (a_rd_addr),
    .a_valid    (a_valid),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_acc      (o_acc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Transaction-level model: an accepted command fills in the expected
  // outputs for every future cycle it touches.
  function automatic void scheduleCmd(int c, int w, int a, int o, int rows, bit acc);
    int r;
    int last;
    r = (rows > DEPTH) ? DEPTH : rows;
    if (r == 0) begin
      sched[c+1].done = 1'b1;
      return;
    end
    for (int k = 0; k < NROWS; k++) begin
      sched[c+1+k].wEn   = 1'b1;
      sched[c+1+k].wAddr = (w + k) % DEPTH;
      sched[c+2+k].wLoad = 1'b1;
    end
    for (int i = 0; i < r; i++) begin
      sched[c+1+NROWS+i].aEn        = 1'b1;
      sched[c+1+NROWS+i].aAddr      = (a + i) % DEPTH;
      sched[c+2+NROWS+i].aValid     = 1'b1;
      sched[c+1+NROWS+i+LAT].oEn    = 1'b1;
      sched[c+1+NROWS+i+LAT].oAddr  = (o + i) % DEPTH;
      sched[c+1+NROWS+i+LAT].oAcc   = acc;
    end
    last = c + NROWS + r + LAT;
    for (int t = c + 1; t <= last; t++) sched[t].busy = 1'b1;
    sched[last+1].done = 1'b1;
  endfunction

  function automatic void cancelAfter(int t);
    for (int u = t + 1; u < MAXC; u++) sched[u] = '{default: 0};
  endfunction

  // Compare every output against the model mid-cycle, log the events the
  // directed scenarios inspect, then advance the model on this cycle's inputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n)
      for (int u = cyc; u < MAXC; u++) sched[u] = '{default: 0};
    e = (cyc < MAXC) ? sched[cyc] : '{default: 0};
    checkOutput("w_rd_en",   w_rd_en,   e.wEn);
    checkOutput("w_rd_addr", w_rd_addr, e.wAddr);
    checkOutput("w_load",    w_load,    e.wLoad);
    checkOutput("a_rd_en",   a_rd_en,   e.aEn);
    checkOutput("a_rd_addr", a_rd_addr, e.aAddr);
    checkOutput("a_valid",   a_valid,   e.aValid);
    checkOutput("o_wr_en",   o_wr_en,   e.oEn);
    checkOutput("o_wr_addr", o_wr_addr, e.oAddr);
    checkOutput("o_acc",     o_acc,     e.oAcc);
    checkOutput("done",      done,      e.done);
    checkOutput("busy",      busy,      e.busy);
    checkOutput("cmd_ready", cmd_ready, !e.busy);
    if (o_wr_en) begin oWrCyc.push_back(cyc); oWrAddr.push_back(int'(o_wr_addr)); end
    if (a_rd_en) begin aRdCyc.push_back(cyc); aRdAddr.push_back(int'(a_rd_addr)); end
    if (w_rd_en) wRdCyc.push_back(cyc);
    if (done)    doneCyc.push_back(cyc);
    if (rst_n && cmd_valid && !e.busy)
      scheduleCmd(cyc, int'(cmd_w_base), int'(cmd_a_base), int'(cmd_o_base), int'(cmd_rows), cmd_acc);
    else if (rst_n && abort && e.busy)
      cancelAfter(cyc);
  end

  task automatic applyStimulus(input bit v, input int w, input int a, input int o,
                               input int rows, input bit acc, input bit ab);
    @(posedge clk);
    #1;
    cmd_valid  = v;
    cmd_w_base = 7'(w);
    cmd_a_base = 7'(a);
    cmd_o_base = 7'(o);
    cmd_rows   = 8'(rows);
    cmd_acc    = acc;
    abort      = ab;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issueCmd(input int w, input int a, input int o, input int rows,
                          input bit acc, output int c);
    applyStimulus(1, w, a, o, rows, acc, 0);
    c = cyc;
  endtask

  task automatic clearLogs();
    oWrCyc.delete(); oWrAddr.delete(); aRdCyc.delete(); aRdAddr.delete();
    wRdCyc.delete(); doneCyc.delete();
  endtask

  initial begin
    int c;
    int c2;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_w_base = '0;
    cmd_a_base = '0;
    cmd_o_base = '0;
    cmd_rows   = '0;
    cmd_acc    = 1'b0;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset busy", busy, 0);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] base tile");
    clearLogs();
    issueCmd(0, 10, 20, 4, 0, c);
    idleCycles(35);
    checkOutput("base w_rd count", wRdCyc.size(), 8);
    checkOutput("base w_rd first", wRdCyc[0] - c, 1);
    checkOutput("base a_rd count", aRdCyc.size(), 4);
    checkOutput("base a_rd first", aRdCyc[0] - c, 9);
    checkOutput("base a_rd last", aRdCyc[3] - c, 12);
    checkOutput("base a_rd addr0", aRdAddr[0], 10);
    checkOutput("base o_wr count", oWrCyc.size(), 4);
    checkOutput("base o_wr first", oWrCyc[0] - c, 25);
    checkOutput("base o_wr last", oWrCyc[3] - c, 28);
    checkOutput("base o_wr addr0", oWrAddr[0], 20);
    checkOutput("base o_wr addr3", oWrAddr[3], 23);
    checkOutput("base done count", doneCyc.size(), 1);
    checkOutput("base done cycle", doneCyc[0] - c, 29);

    $display("[TB] address wrap");
    clearLogs();
    issueCmd(5, 126, 127, 4, 1, c);
    idleCycles(35);
    checkOutput("wrap a count", aRdAddr.size(), 4);
    checkOutput("wrap a1", aRdAddr[1], 127);
    checkOutput("wrap a2", aRdAddr[2], 0);
    checkOutput("wrap a3", aRdAddr[3], 1);
    checkOutput("wrap o count", oWrAddr.size(), 4);
    checkOutput("wrap o0", oWrAddr[0], 127);
    checkOutput("wrap o1", oWrAddr[1], 0);
    checkOutput("wrap o3", oWrAddr[3], 2);

    $display("[TB] abort mid-stream");
    clearLogs();
    issueCmd(0, 10, 20, 4, 0, c);
    idleCycles(10);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    issueCmd(1, 2, 3, 2, 0, c2);
    checkOutput("abort accept cycle", c2 - c, 12);
    checkOutput("abort idle busy", busy, 0);
    checkOutput("abort idle a_valid", a_valid, 0);
    idleCycles(20);
    checkOutput("abort no writes", oWrCyc.size(), 0);
    checkOutput("abort no done", doneCyc.size(), 0);
    idleCycles(15);
    checkOutput("post-abort done count", doneCyc.size(), 1);
    checkOutput("post-abort done cycle", doneCyc[0] - c2, 27);

    $display("[TB] empty tile");
    clearLogs();
    issueCmd(0, 0, 0, 0, 1, c);
    idleCycles(5);
    checkOutput("rows0 done cycle", doneCyc[0] - c, 1);
    checkOutput("rows0 accesses", wRdCyc.size() + aRdCyc.size() + oWrCyc.size(), 0);

    $display("[TB] clamped tile");
    clearLogs();
    issueCmd(3, 7, 9, 200, 1, c);
    idleCycles(160);
    checkOutput("clamp a_rd count", aRdCyc.size(), 128);
    checkOutput("clamp o_wr count", oWrCyc.size(), 128);
    checkOutput("clamp done cycle", doneCyc[0] - c, 153);

    $display("[TB] reset mid-tile");
    issueCmd(0, 10, 20, 4, 0, c);
    idleCycles(14);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst busy", busy, 0);
    checkOutput("rst cmd_ready", cmd_ready, 1);
    checkOutput("rst o_wr_en", o_wr_en, 0);
    checkOutput("rst a_valid", a_valid, 0);
    clearLogs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(40);
    checkOutput("rst no writes", oWrCyc.size(), 0);
    checkOutput("rst no done", doneCyc.size(), 0);
    checkOutput("rst ready after", cmd_ready, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2500; i++) begin
      int r;
      int rows;
      r = $urandom_range(0, 19);
      if (r == 0)      rows = 0;
      else if (r == 1) rows = $urandom_range(129, 255);
      else if (r < 4)  rows = $urandom_range(100, 128);
      else             rows = $urandom_range(1, 12);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 127), $urandom_range(0, 127),
                    $urandom_range(0, 127), rows, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 79) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idleCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL take parameters from the shared package: SMALL_SYS_ROWS (default 8, PE rows), SMALL_SYS_COLS (default 8, PE cols), SCRATCHPAD_DEPTH (default 128, words per scratchpad).
REQ-002 SHALL derive ADDR_W = clog2(SCRATCHPAD_DEPTH) (7) and PIPE_LAT = SMALL_SYS_ROWS+SMALL_SYS_COLS (16) as local constants.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  async active-low reset.
- cmd_valid / cmd_ready  in / out  1  tile command handshake.
- cmd_w_base, cmd_a_base, cmd_o_base  in  ADDR_W  weight, activation and output base addresses.
- cmd_rows  in  ADDR_W+1  activation rows in the tile.
- cmd_acc  in  1  accumulate into the existing output.
- abort  in  1  synchronous cancel.
- w_rd_en / w_rd_addr  out  1 / ADDR_W  weight scratchpad read.
- w_load  out  1  systolic weight-shift enable.
- a_rd_en / a_rd_addr  out  1 / ADDR_W  activation scratchpad read.
- a_valid  out  1  activation row entering the array.
- o_wr_en / o_wr_addr / o_acc  out  1 / ADDR_W / 1  accumulator write.
- busy  out  1  not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN.
REQ-006 cmd_ready SHALL be 1 only in IDLE.
REQ-007 On a handshake (cmd_valid & cmd_ready), SHALL capture all cmd_* fields and enter LOAD_W.
REQ-008 LOAD_W SHALL assert w_rd_en for exactly SMALL_SYS_ROWS consecutive cycles, starting the cycle after acceptance, with w_rd_addr = w_base+k (k = 0..SMALL_SYS_ROWS-1).
REQ-009 STREAM SHALL assert a_rd_en for exactly rows consecutive cycles, directly following LOAD_W, with a_rd_addr = a_base+i.
REQ-010 All address arithmetic SHALL be modulo SCRATCHPAD_DEPTH (127+1 wraps to 0).
REQ-011 Scratchpad read latency is 1 cycle: w_load SHALL equal w_rd_en delayed by 1 cycle, and a_valid SHALL equal a_rd_en delayed by 1 cycle.
REQ-012 Writes: o_wr_en for row i SHALL assert exactly PIPE_LAT cycles after a_rd_en for row i, with o_wr_addr = o_base+i and o_acc = captured cmd_acc.
REQ-013 DRAIN SHALL be entered after the last a_rd_en and held until the last o_wr_en has issued.
REQ-014 done SHALL pulse for 1 cycle the cycle after the last o_wr_en; the FSM SHALL be in IDLE in that same cycle.
REQ-015 cmd_rows = 0: no weight, activation or output accesses; done SHALL pulse the cycle after acceptance.
REQ-016 cmd_rows > SCRATCHPAD_DEPTH SHALL be clamped to SCRATCHPAD_DEPTH.
REQ-017 abort high at a clock edge while not in IDLE:
- next state IDLE;
- all *_en, w_load and a_valid low next cycle;
- in-flight delayed writes discarded;
- no done pulse.
REQ-018 abort in IDLE SHALL be ignored, including when coincident with cmd_valid (the command is accepted).
REQ-019 busy SHALL be 1 in every non-IDLE state.
REQ-020 Back-to-back commands: the next command SHALL be accepted no earlier than the done cycle.

Reset
REQ-021 rst_n low SHALL force state IDLE and clear captured fields, counters and delay lines.
REQ-022 While rst_n is low: every output 0 except cmd_ready = 1; all addresses 0.
REQ-023 Reset asserted mid-tile SHALL abandon the tile with no further write or done.

Structure
REQ-024 ADDR_W, PIPE_LAT and the FSM state enum SHALL live in the shared package alongside the existing array/scratchpad parameters.
REQ-025 The PIPE_LAT-deep write delay line (valid + row index) SHALL be a sub-module named delay_line.

Verification
REQ-026 Base case, rows=4, w_base=0, a_base=10, o_base=20, acc=0, accept at cycle 0:
- w_rd_en cycles 1-8 (addr 0-7);
- a_rd_en cycles 9-12 (addr 10-13);
- o_wr_en cycles 25-28 (addr 20-23);
- done cycle 29.
REQ-027 Wrap: a_base=126, rows=4 -> a_rd_addr 126,127,0,1; o_base=127 -> o_wr_addr 127,0,1,2.
REQ-028 Abort at cycle 11 of the REQ-026 case -> cycle 12 idle with all enables low, no o_wr_en ever, no done; a new command is accepted at cycle 12.
REQ-029 rows=0 -> done at cycle 1 with no accesses; rows=200 -> exactly 128 a_rd_en and 128 o_wr_en.
REQ-030 rst_n low at cycle 15 of the REQ-026 case -> outputs reset immediately (asynchronously); after release, cmd_ready=1 and no stray writes.
